// File: rtl/cpu_defs_pkg.sv
// Shared ISA definitions for the decode stage: opcodes, ALU commands, field positions, ID/EX bundle.
// Pure definitions; no latency or flow control of its own.
package cpu_defs_pkg;

  localparam int DATA_W    = 32;
  localparam int REG_COUNT = 32;
  localparam int REG_AW    = 5;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;
  localparam int IMM_MSB = 15;

  typedef logic [5:0] opcode_t;
  localparam opcode_t OP_NOP  = 6'd0;
  localparam opcode_t OP_ADD  = 6'd1;
  localparam opcode_t OP_SUB  = 6'd3;
  localparam opcode_t OP_AND  = 6'd5;
  localparam opcode_t OP_OR   = 6'd6;
  localparam opcode_t OP_NOR  = 6'd7;
  localparam opcode_t OP_XOR  = 6'd8;
  localparam opcode_t OP_SLA  = 6'd9;
  localparam opcode_t OP_SLL  = 6'd10;
  localparam opcode_t OP_SRA  = 6'd11;
  localparam opcode_t OP_SRL  = 6'd12;
  localparam opcode_t OP_ADDI = 6'd32;
  localparam opcode_t OP_SUBI = 6'd33;
  localparam opcode_t OP_LD   = 6'd36;
  localparam opcode_t OP_ST   = 6'd37;
  localparam opcode_t OP_BEZ  = 6'd40;
  localparam opcode_t OP_BNE  = 6'd41;
  localparam opcode_t OP_JMP  = 6'd42;

  typedef logic [3:0] exe_cmd_t;
  localparam exe_cmd_t EXE_ADD = 4'd0;
  localparam exe_cmd_t EXE_SUB = 4'd1;
  localparam exe_cmd_t EXE_AND = 4'd2;
  localparam exe_cmd_t EXE_OR  = 4'd3;
  localparam exe_cmd_t EXE_NOR = 4'd4;
  localparam exe_cmd_t EXE_XOR = 4'd5;
  localparam exe_cmd_t EXE_SLA = 4'd6;
  localparam exe_cmd_t EXE_SLL = 4'd7;
  localparam exe_cmd_t EXE_SRA = 4'd8;
  localparam exe_cmd_t EXE_SRL = 4'd9;
  localparam exe_cmd_t EXE_NOP = 4'd15;

  typedef struct packed {
    exe_cmd_t            cmd;
    logic [DATA_W-1:0]   val1;
    logic [DATA_W-1:0]   val2;
    logic [DATA_W-1:0]   st_val;
    logic [REG_AW-1:0]   dest;
    logic                wb_en;
    logic                mem_r_en;
    logic                mem_w_en;
    logic [DATA_W-1:0]   pc;
  } id_ex_t;

  function automatic id_ex_t nop_bundle();
    id_ex_t b;
    b     = '0;
    b.cmd = EXE_NOP;
    return b;
  endfunction

  function automatic logic [DATA_W-1:0] sext16(input logic [IMM_MSB:0] imm);
    return {{(DATA_W-IMM_MSB-1){imm[IMM_MSB]}}, imm};
  endfunction

endpackage

// File: rtl/register_file.sv
// 32-entry register file: two async read ports, one write port, r0 hardwired to zero.
// Reads see a same-cycle write (write-through); no backpressure.
module register_file
  import cpu_defs_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rd_addr1,
  input  logic [REG_AW-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wr_en,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] regs [REG_COUNT];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (wr_en && wr_addr != '0) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data1 = regs[rd_addr1];
    if (rd_addr1 == '0)                       rd_data1 = '0;
    else if (wr_en && wr_addr == rd_addr1)    rd_data1 = wr_data;
  end

  always_comb begin
    rd_data2 = regs[rd_addr2];
    if (rd_addr2 == '0)                       rd_data2 = '0;
    else if (wr_en && wr_addr == rd_addr2)    rd_data2 = wr_data;
  end

endmodule

// File: rtl/id_stage.sv
// Decode stage: IF/ID register, regfile read, decode, branch resolve, RAW stall; registered ID/EX bundle.
// Two edges fetch-to-EX; any RAW hazard against EX or MEM holds IF/ID and bubbles ID/EX.
module id_stage
  import cpu_defs_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] if_instruction,
  input  logic [DATA_W-1:0] if_pc,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_dest,
  input  logic [DATA_W-1:0] wb_value,
  input  logic              mem_wb_en,
  input  logic [REG_AW-1:0] mem_dest,
  output logic              branch_taken,
  output logic [DATA_W-1:0] branch_address,
  output logic              hazard_stall,
  output logic [3:0]        ex_cmd,
  output logic [DATA_W-1:0] ex_val1,
  output logic [DATA_W-1:0] ex_val2,
  output logic [DATA_W-1:0] ex_st_val,
  output logic [REG_AW-1:0] ex_dest,
  output logic              ex_wb_en,
  output logic              ex_mem_r_en,
  output logic              ex_mem_w_en,
  output logic [DATA_W-1:0] ex_pc
);

  logic [DATA_W-1:0] if_id_instr, if_id_pc;
  id_ex_t            id_ex_q, decoded;

  opcode_t           op;
  logic [REG_AW-1:0] rs, rt, rd;
  logic [DATA_W-1:0] imm_sext, rv1, rv2;

  assign op       = if_id_instr[OP_MSB:OP_LSB];
  assign rs       = if_id_instr[RS_MSB:RS_LSB];
  assign rt       = if_id_instr[RT_MSB:RT_LSB];
  assign rd       = if_id_instr[RD_MSB:RD_LSB];
  assign imm_sext = sext16(if_id_instr[IMM_MSB:0]);

  register_file u_regfile (
    .clk      (clk),
    .rst      (rst),
    .rd_addr1 (rs),
    .rd_addr2 (rt),
    .rd_data1 (rv1),
    .rd_data2 (rv2),
    .wr_en    (wb_en),
    .wr_addr  (wb_dest),
    .wr_data  (wb_value)
  );

  exe_cmd_t          cmd;
  logic [REG_AW-1:0] dest;
  logic              dec_wb, dec_mr, dec_mw, use_imm, uses_rs, uses_rt, rtype;
  logic              is_bez, is_bne, is_jmp;

  // Everything defaults to NOP so unknown or X opcodes never reach control.
  always_comb begin
    cmd = EXE_NOP; dest = '0; dec_wb = 1'b0; dec_mr = 1'b0; dec_mw = 1'b0;
    use_imm = 1'b0; uses_rs = 1'b0; uses_rt = 1'b0; rtype = 1'b0;
    is_bez = 1'b0; is_bne = 1'b0; is_jmp = 1'b0;
    case (op)
      OP_ADD:  begin cmd = EXE_ADD; rtype = 1'b1; end
      OP_SUB:  begin cmd = EXE_SUB; rtype = 1'b1; end
      OP_AND:  begin cmd = EXE_AND; rtype = 1'b1; end
      OP_OR:   begin cmd = EXE_OR;  rtype = 1'b1; end
      OP_NOR:  begin cmd = EXE_NOR; rtype = 1'b1; end
      OP_XOR:  begin cmd = EXE_XOR; rtype = 1'b1; end
      OP_SLA:  begin cmd = EXE_SLA; rtype = 1'b1; end
      OP_SLL:  begin cmd = EXE_SLL; rtype = 1'b1; end
      OP_SRA:  begin cmd = EXE_SRA; rtype = 1'b1; end
      OP_SRL:  begin cmd = EXE_SRL; rtype = 1'b1; end
      OP_ADDI: begin cmd = EXE_ADD; dest = rt; dec_wb = 1'b1; uses_rs = 1'b1; use_imm = 1'b1; end
      OP_SUBI: begin cmd = EXE_SUB; dest = rt; dec_wb = 1'b1; uses_rs = 1'b1; use_imm = 1'b1; end
      OP_LD:   begin cmd = EXE_ADD; dest = rt; dec_wb = 1'b1; dec_mr = 1'b1; uses_rs = 1'b1; use_imm = 1'b1; end
      OP_ST:   begin cmd = EXE_ADD; dec_mw = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; use_imm = 1'b1; end
      OP_BEZ:  begin is_bez = 1'b1; uses_rs = 1'b1; end
      OP_BNE:  begin is_bne = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; end
      OP_JMP:  is_jmp = 1'b1;
      OP_NOP:  ;
      default: ;
    endcase
    if (rtype) begin
      dest = rd; dec_wb = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1;
    end
  end

  logic rs_hit, rt_hit, branch_cond;

  assign rs_hit = uses_rs && (rs != '0) &&
                  ((id_ex_q.wb_en && id_ex_q.dest == rs) || (mem_wb_en && mem_dest == rs));
  assign rt_hit = uses_rt && (rt != '0) &&
                  ((id_ex_q.wb_en && id_ex_q.dest == rt) || (mem_wb_en && mem_dest == rt));
  assign hazard_stall = rs_hit || rt_hit;

  // A branch waiting on its operands must not redirect with stale register values.
  assign branch_cond    = is_jmp || (is_bez && rv1 == '0) || (is_bne && rv1 != rv2);
  assign branch_taken   = branch_cond && !hazard_stall;
  assign branch_address = if_id_pc + DATA_W'(4) + {imm_sext[DATA_W-3:0], 2'b00};

  always_comb begin
    decoded = nop_bundle();
    if (cmd != EXE_NOP) begin
      decoded.cmd      = cmd;
      decoded.val1     = rv1;
      decoded.val2     = use_imm ? imm_sext : rv2;
      decoded.st_val   = rv2;
      decoded.dest     = dest;
      decoded.wb_en    = dec_wb;
      decoded.mem_r_en = dec_mr;
      decoded.mem_w_en = dec_mw;
      decoded.pc       = if_id_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if_id_instr <= '0;
      if_id_pc    <= '0;
      id_ex_q     <= '0;
    end else if (hazard_stall) begin
      id_ex_q     <= nop_bundle();
    end else if (branch_taken) begin
      if_id_instr <= '0;
      if_id_pc    <= '0;
      id_ex_q     <= nop_bundle();
    end else begin
      if_id_instr <= if_instruction;
      if_id_pc    <= if_pc;
      id_ex_q     <= decoded;
    end
  end

  assign ex_cmd      = id_ex_q.cmd;
  assign ex_val1     = id_ex_q.val1;
  assign ex_val2     = id_ex_q.val2;
  assign ex_st_val   = id_ex_q.st_val;
  assign ex_dest     = id_ex_q.dest;
  assign ex_wb_en    = id_ex_q.wb_en;
  assign ex_mem_r_en = id_ex_q.mem_r_en;
  assign ex_mem_w_en = id_ex_q.mem_w_en;
  assign ex_pc       = id_ex_q.pc;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed program, EX/MEM/WB feedback model, scoreboard queue checked by a monitor.
`timescale 1ns/1ps
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_instruction, if_pc, wb_value;
  logic        wb_en, mem_wb_en;
  logic [4:0]  wb_dest, mem_dest;
  logic        branch_taken, hazard_stall;
  logic [31:0] branch_address;
  logic [3:0]  ex_cmd;
  logic [31:0] ex_val1, ex_val2, ex_st_val, ex_pc;
  logic [4:0]  ex_dest;
  logic        ex_wb_en, ex_mem_r_en, ex_mem_w_en;

  id_stage dut (
    .clk(clk), .rst(rst), .if_instruction(if_instruction), .if_pc(if_pc),
    .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
    .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
    .branch_taken(branch_taken), .branch_address(branch_address), .hazard_stall(hazard_stall),
    .ex_cmd(ex_cmd), .ex_val1(ex_val1), .ex_val2(ex_val2), .ex_st_val(ex_st_val),
    .ex_dest(ex_dest), .ex_wb_en(ex_wb_en), .ex_mem_r_en(ex_mem_r_en),
    .ex_mem_w_en(ex_mem_w_en), .ex_pc(ex_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] v1, v2, st;
    logic [4:0]  dest;
    logic        wb, mr, mw;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  exp_t got_e;
  int   tests = 0;
  int   fails = 0;

  function automatic exp_t mk(input int cmd, input int v1, input int v2, input int st,
                              input int dest, input bit wb, input bit mr, input bit mw, input int pc);
    exp_t e;
    e.cmd = cmd[3:0]; e.v1 = v1; e.v2 = v2; e.st = st; e.dest = dest[4:0];
    e.wb = wb; e.mr = mr; e.mw = mw; e.pc = pc;
    return e;
  endfunction

  function automatic logic [31:0] r_ins(input int op, input int rd, input int rs, input int rt);
    return {op[5:0], rs[4:0], rt[4:0], rd[4:0], 11'd0};
  endfunction

  function automatic logic [31:0] i_ins(input int op, input int rt, input int rs, input int imm);
    return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual %0d (0x%0h), required %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  task automatic check_ex_zero(input string tag);
    check({tag, "_cmd"}, 32'(ex_cmd), 0);
    check({tag, "_val1"}, ex_val1, 0);
    check({tag, "_val2"}, ex_val2, 0);
    check({tag, "_st_val"}, ex_st_val, 0);
    check({tag, "_dest"}, 32'(ex_dest), 0);
    check({tag, "_ctrl"}, {29'd0, ex_wb_en, ex_mem_r_en, ex_mem_w_en}, 0);
    check({tag, "_pc"}, ex_pc, 0);
    check({tag, "_branch_taken"}, 32'(branch_taken), 0);
    check({tag, "_hazard_stall"}, 32'(hazard_stall), 0);
  endtask

  // EX -> MEM -> WB feedback: ex_* seen after edge k is in MEM after k+1, in WB after k+2.
  logic        s_en, m_en;
  logic [4:0]  s_dest, m_dest;
  logic [31:0] s_val, m_val;
  initial begin
    s_en = 0; m_en = 0; s_dest = 0; m_dest = 0; s_val = 0; m_val = 0;
    wb_en = 0; wb_dest = 0; wb_value = 0; mem_wb_en = 0; mem_dest = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        s_en = 0; m_en = 0; s_dest = 0; m_dest = 0; s_val = 0; m_val = 0;
        wb_en = 0; wb_dest = 0; wb_value = 0;
      end else begin
        wb_en = m_en; wb_dest = m_dest; wb_value = m_val;
        m_en = s_en; m_dest = s_dest; m_val = s_val;
        s_en = ex_wb_en; s_dest = ex_dest;
        s_val = (ex_cmd == 4'd1) ? ex_val1 - ex_val2 : ex_val1 + ex_val2;
      end
      mem_wb_en = m_en;
      mem_dest  = m_dest;
    end
  end

  // Monitor: every real instruction leaving ID is matched against the next expected bundle.
  initial begin
    forever begin
      @(negedge clk);
      if (rst && (ex_wb_en || ex_mem_r_en || ex_mem_w_en)) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_ex: actual pc=%0d dest=%0d cmd=%0d, required no instruction", ex_pc, ex_dest, ex_cmd);
        end else begin
          got_e = sb.pop_front();
          if (ex_cmd !== got_e.cmd || ex_val1 !== got_e.v1 || ex_val2 !== got_e.v2 ||
              ex_dest !== got_e.dest || ex_wb_en !== got_e.wb || ex_mem_r_en !== got_e.mr ||
              ex_mem_w_en !== got_e.mw || ex_pc !== got_e.pc || (got_e.mw && ex_st_val !== got_e.st)) begin
            fails++;
            $display("FAIL ex_bundle: actual cmd=%0d v1=%0d v2=%0d st=%0d dest=%0d wb=%0b mr=%0b mw=%0b pc=%0d, required cmd=%0d v1=%0d v2=%0d st=%0d dest=%0d wb=%0b mr=%0b mw=%0b pc=%0d",
                     ex_cmd, ex_val1, ex_val2, ex_st_val, ex_dest, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_pc,
                     got_e.cmd, got_e.v1, got_e.v2, got_e.st, got_e.dest, got_e.wb, got_e.mr, got_e.mw, got_e.pc);
          end
        end
      end
    end
  end

  task automatic settle();
    int n = 0;
    while (hazard_stall && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (hazard_stall) begin
      tests++;
      fails++;
      $display("FAIL stall_timeout: actual stall still 1 after %0d cycles, required release", n);
    end
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
    settle();
    if_instruction = ins;
    if_pc          = pc;
    @(negedge clk);
  endtask

  task automatic issue_exp(input logic [31:0] ins, input logic [31:0] pc, input exp_t e);
    settle();
    sb.push_back(e);
    issue(ins, pc);
  endtask

  logic [31:0] bne, xins;

  initial begin
    rst = 1'b0;
    if_instruction = 32'hDEAD_BEEF;
    if_pc = 32'h0000_1234;
    repeat (3) @(negedge clk);
    check_ex_zero("reset");
    rst = 1'b1;

    // RAW stall on r1, then the dependent add sees the written value
    issue_exp(i_ins(32, 1, 0, 1546), 0,  mk(0, 0, 1546, 0, 1, 1, 0, 0, 0));
    issue_exp(r_ins(1, 2, 0, 1),      4,  mk(0, 0, 1546, 0, 2, 1, 0, 0, 4));

    // write-through on r5, and r0 ignoring writes
    issue_exp(i_ins(32, 5, 0, 1546), 8,  mk(0, 0, 1546, 0, 5, 1, 0, 0, 8));
    issue_exp(r_ins(1, 6, 5, 0),      12, mk(0, 1546, 0, 0, 6, 1, 0, 0, 12));
    issue_exp(i_ins(32, 0, 0, 77),   16, mk(0, 0, 77, 0, 0, 1, 0, 0, 16));
    repeat (3) issue(32'd0, 20);
    issue_exp(r_ins(1, 7, 0, 0),      32, mk(0, 0, 0, 0, 7, 1, 0, 0, 32));
    repeat (4) issue(32'd0, 36);

    // BEZ taken with flush of the wrong-path fetch
    issue(i_ins(40, 0, 9, 2), 288);
    settle();
    check("bez_taken", 32'(branch_taken), 1);
    check("bez_target", branch_address, 300);
    issue(i_ins(32, 10, 0, 5), 292);
    check("bez_bubble_cmd", 32'(ex_cmd), 15);
    check("bez_bubble_wb", 32'(ex_wb_en), 0);
    check("bez_flushed_ifid", 32'(branch_taken), 0);
    issue_exp(i_ins(32, 11, 0, 7), 300, mk(0, 0, 7, 0, 11, 1, 0, 0, 300));

    // BNE not taken on equal, taken on unequal
    issue_exp(i_ins(32, 1, 0, 3), 304, mk(0, 0, 3, 0, 1, 1, 0, 0, 304));
    issue_exp(i_ins(32, 3, 0, 3), 308, mk(0, 0, 3, 0, 3, 1, 0, 0, 308));
    bne = i_ins(41, 3, 1, -30);
    issue(bne, 320);
    settle();
    check("bne_equal_not_taken", 32'(branch_taken), 0);
    issue_exp(i_ins(32, 3, 0, 2), 324, mk(0, 0, 2, 0, 3, 1, 0, 0, 324));
    issue(bne, 320);
    settle();
    check("bne_unequal_taken", 32'(branch_taken), 1);
    check("bne_target", branch_address, 204);
    issue(i_ins(32, 10, 0, 9), 324);

    // unknown opcode, opcode 0 with X fields, store
    issue(32'hFFFF_FFFF, 400);
    issue(32'd0, 404);
    check("unknown_cmd", 32'(ex_cmd), 15);
    check("unknown_ctrl", {29'd0, ex_wb_en, ex_mem_r_en, ex_mem_w_en}, 0);
    xins = {6'd0, 26'bx};
    issue(xins, 408);
    check("xfields_stall", 32'(hazard_stall), 0);
    issue(32'd0, 412);
    check("xfields_cmd", 32'(ex_cmd), 15);
    check("xfields_ctrl", {29'd0, ex_wb_en, ex_mem_r_en, ex_mem_w_en}, 0);
    issue_exp(i_ins(37, 2, 1, 0), 416, mk(0, 3, 0, 1546, 0, 0, 0, 1, 416));
    repeat (4) issue(32'd0, 420);

    // reset mid-stream clears pipeline and registers
    rst = 1'b0;
    if_instruction = 32'h1234_5678;
    repeat (2) @(negedge clk);
    check_ex_zero("midreset");
    rst = 1'b1;
    issue_exp(r_ins(1, 12, 2, 1), 500, mk(0, 0, 0, 0, 12, 1, 0, 0, 500));
    repeat (4) issue(32'd0, 504);

    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: actual %0d pending, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
